// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-128 inverse cipher controller: round count,
// FSM state type, inverse S-box table and the byte-permutation helpers.
// Byte i of a 128-bit block sits at [127-8i -: 8]; row = i % 4, column = i / 4.
package aes_dec_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StDone
  } dec_state_e;

  // Entry 0 is the most significant byte of the literal.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/inverseMixColumns.sv
// Combinational AES InvMixColumns over a full 128-bit state, column-major,
// {0e,0b,0d,09} circulant with GF(2^8) reduction polynomial 0x11b.
module inverseMixColumns (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant of at most four bits.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  // Each column is transformed independently.
  always_comb begin
    state_o = '0;
    for (int c = 0; c < 4; c++) begin
      state_o[127-32*c -: 32] = inv_mix_col(state_i[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: one round per accepted round key,
// keys requested from index 10 down to 0, plaintext held until consumed.
// Optional macro AES_DEC_ABORT_EN adds an abort input that drops an in-flight block.
module aes_inv_cipher_ctrl
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         key_req,
  output logic [3:0]   key_idx,
  input  logic         key_vld,
  input  logic [127:0] key_data,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam logic [3:0] LastRnd = 4'(NR);

  dec_state_e   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] ark;
  logic [127:0] imc_out;

  // Shared front half of every non-initial round.
  assign ark = inv_sub_bytes(inv_shift_rows(st_q)) ^ key_data;

  inverseMixColumns u_inv_mix_columns (
    .state_i (ark),
    .state_o (imc_out)
  );

  // Handshake and key-request outputs decoded from the current state.
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
`ifdef AES_DEC_ABORT_EN
    in_ready  = in_ready && !abort;
`endif
    key_req   = (state_q == StRound);
    key_idx   = key_req ? rnd_q : 4'd0;
    out_valid = (state_q == StDone);
    busy      = (state_q == StRound) || (state_q == StDone);
    data_out  = st_q;
  end

  // Next-state: accept, one round per valid key, release on out_ready.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          st_d    = data_in;
          rnd_d   = LastRnd;
          state_d = StRound;
        end
      end
      StRound: begin
        if (key_vld) begin
          if (rnd_q == LastRnd) begin
            st_d  = st_q ^ key_data;
            rnd_d = rnd_q - 4'd1;
          end else if (rnd_q == 4'd0) begin
            st_d    = ark;
            state_d = StDone;
          end else begin
            st_d  = imc_out;
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef AES_DEC_ABORT_EN
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      st_d    = '0;
      rnd_d   = '0;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      st_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule
